pipeline_control: RTL

//   Sequences the 5-stage pipeline latches and PC. Merges cache handshakes (ihit/dhit) with

---
 rtl/datapath_types_pkg.sv | 20 ++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_control.sv | 127 ++++++++++++
 3 files changed

// File: rtl/datapath_types_pkg.sv
// ============================================================================
// datapath_types_pkg
//   Shared types for the pipeline sequencing logic.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package datapath_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  localparam int unsigned C_DEF_CNT_W = 32;

endpackage : datapath_types_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;
  assign count  = r_count;

  // Count requested events, holding once the counter is full.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipeline_control.sv
// ============================================================================
// pipeline_control
//   Turns cache handshakes and hazard decisions into per-latch enable and
//   flush strobes for a 5-stage pipeline, and masks a finished data access
//   while the front end is still waiting for its instruction.
//   Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_control
  import datapath_types_pkg::*;
#(
  parameter int unsigned CNT_W = C_DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             flush,
  input  logic             insert_nop,
  input  logic             halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             dmem_mask,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] nop_cnt
);

  pipe_state_t r_state;

  logic w_adv;     // memory handshakes allow the pipeline to move
  logic w_go;      // pipeline actually moves (halt overrides)
  logic w_front;   // IF side (PC, IF/ID) may load
  logic w_active;  // not halted

  // Advance condition depends on whether the data access already completed.
  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      RUN:     w_adv = ihit && (!dmem_req || dhit);
      DDONE:   w_adv = ihit;
      default: w_adv = 1'b0;
    endcase
  end

  assign w_active = (r_state != HALTED);
  assign w_go     = w_adv && !halt;
  // A load-use bubble holds the front end, unless a flush squashes the victim.
  assign w_front  = w_go && (flush || !insert_nop);

  assign pc_en       = w_front;
  assign if_id_en    = w_front;
  assign id_ex_en    = w_go;
  assign ex_mem_en   = w_go;
  assign mem_wb_en   = w_go;
  assign if_id_flush = w_go && flush;
  assign id_ex_flush = w_go && (flush || insert_nop);
  assign dmem_mask   = (r_state == DDONE) || (r_state == HALTED);
  assign halted      = (r_state == HALTED);

  // Sequencing state: remember a completed data access, and latch halt forever.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (halt)                          r_state <= HALTED;
          else if (dmem_req && dhit && !ihit) r_state <= DDONE;
        end
        DDONE: begin
          if (halt)      r_state <= HALTED;
          else if (ihit) r_state <= RUN;
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic w_inc_stall;
  logic w_inc_flush;
  logic w_inc_nop;

  assign w_inc_stall = w_active && !w_adv;
  assign w_inc_flush = w_active && w_go && flush;
  assign w_inc_nop   = w_active && w_go && insert_nop && !flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_inc_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_inc_flush),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_nop_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_inc_nop),
    .count (nop_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign nop_cnt   = '0;
`endif

endmodule : pipeline_control

`default_nettype wire
